poly_mem_writer: RTL and testbench

Write-side companion to the norm-check memory reader. Accepts a stream of polynomial coefficients, 4 per beat, under a valid/ready handshake and writes one 4-coefficient word per cycle to MLDSA_N/4 consecutive addresses starting at mem_base_addr. A zero-fill mode writes all-zero words with no input stream, for clearing a polynomial region. Sits between sampler/NTT-style producers and the shared polynomial memory; the HLC sequences it with enable/done/ready, as it does for norm check.

---
 rtl/poly_mem_writer_if.sv | 32 +++
 rtl/poly_mem_writer.sv | 166 ++++++++++++++++
 tb/tb_poly_mem_writer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/poly_mem_writer_if.sv
// Shared types and the stream/memory-write bundle for the polynomial memory writer.
// The writer consumes coefficient beats and produces one word write per cycle.
package poly_mem_writer_pkg;
    localparam int REG_SIZE           = 24;
    localparam int ABR_MEM_ADDR_WIDTH = 15;
    localparam int NUM_LANES          = 4;

    typedef enum logic [1:0] {
        RW_IDLE  = 2'd0,
        RW_READ  = 2'd1,
        RW_WRITE = 2'd2
    } rw_t;

    typedef struct packed {
        rw_t                           rd_wr_en;
        logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
    } mem_if_t;
endpackage

interface poly_mem_writer_if;
    import poly_mem_writer_pkg::*;

    logic                          data_valid_i;
    logic [NUM_LANES*REG_SIZE-1:0] data_i;
    logic                          data_ready_o;
    mem_if_t                       mem_wr_req;
    logic [NUM_LANES*REG_SIZE-1:0] mem_wr_data;

    // The writer is the slave of the coefficient stream and drives the memory side.
    modport slave  (input  data_valid_i, data_i, output data_ready_o, mem_wr_req, mem_wr_data);
    modport master (output data_valid_i, data_i, input  data_ready_o, mem_wr_req, mem_wr_data);
endinterface

// File: rtl/poly_mem_writer.sv
// Streams 4-coefficient beats (or zeros) into MLDSA_N/4 consecutive memory words,
// then signals wr_done and wr_ready to the sequencer.
module poly_mem_writer_lane #(
    parameter int REG_SIZE = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                zeroize,
    input  logic                i_ld,
    input  logic                i_zero,
    input  logic [REG_SIZE-1:0] i_data,
    output logic [REG_SIZE-1:0] o_data
);
    // Coefficients are stored with the lane MSB cleared.
    localparam logic [REG_SIZE-1:0] LANE_MASK = {1'b0, {(REG_SIZE-1){1'b1}}};

    logic [REG_SIZE-1:0] r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_data <= '0;
        else if (zeroize) r_data <= '0;
        else if (i_ld)    r_data <= i_zero ? '0 : (i_data & LANE_MASK);
    end

    assign o_data = r_data;
endmodule

module poly_mem_writer
    import poly_mem_writer_pkg::*;
#(
    parameter int MLDSA_N = 256
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          zeroize,
    input  logic                          wr_enable,
    input  logic                          zero_fill,
    input  logic [ABR_MEM_ADDR_WIDTH-1:0] mem_base_addr,
    poly_mem_writer_if.slave              bus,
    output logic                          wr_done,
    output logic                          wr_ready
);
    localparam int WORDS = MLDSA_N / 4;
    localparam int CNT_W = $clog2(WORDS) + 1;

    typedef enum logic [1:0] {IDLE, STREAM, FILL, DONE} state_t;

    state_t                          r_state, w_state_nxt;
    logic [CNT_W-1:0]                r_cnt, w_cnt_nxt;
    logic [ABR_MEM_ADDR_WIDTH-1:0]   r_base, w_base_nxt;
    mem_if_t                         r_req, w_req_nxt;
    logic                            r_done, w_done_nxt;
    logic                            r_ready, w_ready_nxt;
    logic                            w_ld, w_zero, w_data_ready, w_accept;
    logic [ABR_MEM_ADDR_WIDTH-1:0]   w_addr;
    logic [NUM_LANES-1:0][REG_SIZE-1:0] w_lane_d, w_lane_q;

    assign w_data_ready = (r_state == STREAM) && (r_cnt < CNT_W'(WORDS));
    assign w_accept     = bus.data_valid_i && w_data_ready;
    assign w_addr       = r_base + ABR_MEM_ADDR_WIDTH'(r_cnt);

    always_comb begin
        w_state_nxt          = r_state;
        w_cnt_nxt            = r_cnt;
        w_base_nxt           = r_base;
        w_req_nxt            = r_req;
        w_req_nxt.rd_wr_en   = RW_IDLE;
        w_done_nxt           = 1'b0;
        w_ready_nxt          = 1'b0;
        w_ld                 = 1'b0;
        w_zero               = 1'b0;
        case (r_state)
            IDLE: begin
                if (wr_enable) begin
                    w_base_nxt = mem_base_addr;
                    w_cnt_nxt  = '0;
                    if (zero_fill) begin
                        // Issue word 0 now so the first fill write lands the cycle after enable.
                        w_state_nxt        = FILL;
                        w_req_nxt.rd_wr_en = RW_WRITE;
                        w_req_nxt.addr     = mem_base_addr;
                        w_cnt_nxt          = CNT_W'(1);
                        w_ld               = 1'b1;
                        w_zero             = 1'b1;
                    end else begin
                        w_state_nxt = STREAM;
                    end
                end
            end
            STREAM: begin
                if (w_accept) begin
                    w_req_nxt.rd_wr_en = RW_WRITE;
                    w_req_nxt.addr     = w_addr;
                    w_cnt_nxt          = r_cnt + 1'b1;
                    w_ld               = 1'b1;
                    if (r_cnt == CNT_W'(WORDS - 1)) w_state_nxt = DONE;
                end
            end
            FILL: begin
                w_req_nxt.rd_wr_en = RW_WRITE;
                w_req_nxt.addr     = w_addr;
                w_cnt_nxt          = r_cnt + 1'b1;
                w_ld               = 1'b1;
                w_zero             = 1'b1;
                if (r_cnt == CNT_W'(WORDS - 1)) w_state_nxt = DONE;
            end
            DONE: begin
                // First DONE cycle carries the last write; wr_done follows, then wr_ready.
                if (!r_done) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_ready_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_base         <= '0;
            r_req.rd_wr_en <= RW_IDLE;
            r_req.addr     <= '0;
            r_done         <= 1'b0;
            r_ready        <= 1'b0;
        end else if (zeroize) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_base         <= '0;
            r_req.rd_wr_en <= RW_IDLE;
            r_req.addr     <= '0;
            r_done         <= 1'b0;
            r_ready        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_base  <= w_base_nxt;
            r_req   <= w_req_nxt;
            r_done  <= w_done_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    assign w_lane_d = bus.data_i;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        poly_mem_writer_lane #(.REG_SIZE(REG_SIZE)) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .zeroize (zeroize),
            .i_ld    (w_ld),
            .i_zero  (w_zero),
            .i_data  (w_lane_d[g]),
            .o_data  (w_lane_q[g])
        );
    end

    assign bus.data_ready_o = w_data_ready;
    assign bus.mem_wr_req   = r_req;
    assign bus.mem_wr_data  = w_lane_q;
    assign wr_done          = r_done;
    assign wr_ready         = r_ready;
endmodule

// File: tb/tb_poly_mem_writer.sv
// Directed bench for poly_mem_writer: stream, gapped stream, masking, zero fill,
// address wrap, zeroize/restart, ignored wr_enable and asynchronous reset.
module tb_poly_mem_writer;
    import poly_mem_writer_pkg::*;

    localparam int AW = ABR_MEM_ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          zeroize, wr_enable, zero_fill;
    logic [AW-1:0] mem_base_addr;
    logic          wr_done, wr_ready;

    poly_mem_writer_if bus();

    poly_mem_writer #(.MLDSA_N(256)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .zeroize       (zeroize),
        .wr_enable     (wr_enable),
        .zero_fill     (zero_fill),
        .mem_base_addr (mem_base_addr),
        .bus           (bus),
        .wr_done       (wr_done),
        .wr_ready      (wr_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int en_cyc = 0;
    int rdy_hi = 0;
    logic [AW-1:0] wr_addr[$];
    logic [95:0]   wr_data[$];
    int            wr_cyc[$];
    int            done_cyc[$];
    int            rdy_cyc[$];
    int            acc_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_wr_req.rd_wr_en == RW_WRITE) begin
            wr_addr.push_back(bus.mem_wr_req.addr);
            wr_data.push_back(bus.mem_wr_data);
            wr_cyc.push_back(cyc);
        end
        if (wr_done)  done_cyc.push_back(cyc);
        if (wr_ready) rdy_cyc.push_back(cyc);
        if (bus.data_valid_i && bus.data_ready_o) acc_cyc.push_back(cyc);
        if (wr_enable) en_cyc <= cyc;
        if (bus.data_ready_o) rdy_hi <= rdy_hi + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] mk(input int k);
        logic [95:0] v;
        for (int i = 0; i < 4; i++) v[i*24 +: 24] = 24'(4*k + i);
        return v;
    endfunction

    task automatic clr_logs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        done_cyc.delete(); rdy_cyc.delete(); acc_cyc.delete();
        rdy_hi = 0;
    endtask

    task automatic start(input logic [AW-1:0] base, input logic zf);
        wr_enable = 1'b1; zero_fill = zf; mem_base_addr = base;
        @(posedge clk); #1;
        wr_enable = 1'b0; zero_fill = 1'b0;
    endtask

    task automatic wait_rdy(input int lim);
        for (int i = 0; i < lim && rdy_cyc.size() == 0; i++) begin
            @(posedge clk); #1;
        end
        chk("rdy_count", rdy_cyc.size(), 1);
    endtask

    // mode: 0 = indexed pattern (with kofs), 1 = all ones masked, 2 = zeros
    task automatic check_writes(input string tag, input logic [AW-1:0] base, input int mode, input int kofs);
        logic [AW-1:0] ea;
        logic [95:0]   ed;
        ea = base;
        chk({tag, "_nwr"}, wr_addr.size(), 64);
        for (int j = 0; j < 64 && j < wr_addr.size(); j++) begin
            ed = (mode == 0) ? mk(j + kofs) : (mode == 1) ? {4{24'h7FFFFF}} : 96'h0;
            chk($sformatf("%s_addr%0d", tag, j), wr_addr[j], ea);
            chk($sformatf("%s_data%0d", tag, j), wr_data[j], ed);
            ea = ea + 1'b1;
        end
    endtask

    task automatic run_stream(input string tag, input logic [AW-1:0] base, input bit toggle,
                              input bit ones, input bit poke, input int kofs);
        int k;
        k = 0;
        clr_logs();
        start(base, 1'b0);
        for (int t = 0; t < 400 && k < 64; t++) begin
            bus.data_valid_i = toggle ? (t % 2 == 0) : 1'b1;
            bus.data_i       = ones ? {96{1'b1}} : mk(k + kofs);
            wr_enable        = poke && (t == 20);
            mem_base_addr    = (poke && t == 20) ? 15'h7000 : base;
            if (bus.data_valid_i && bus.data_ready_o) k++;
            @(posedge clk); #1;
        end
        wr_enable = 1'b0;
        chk({tag, "_beats"}, k, 64);
        bus.data_valid_i = 1'b1;
        chk({tag, "_no65th"}, bus.data_ready_o, 1'b0);
        wait_rdy(10);
        bus.data_valid_i = 1'b0;
        chk({tag, "_ndone"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0 && rdy_cyc.size() > 0 && wr_cyc.size() > 0 && acc_cyc.size() > 0) begin
            chk({tag, "_wrlat"}, wr_cyc[0], acc_cyc[0] + 1);
            chk({tag, "_donelat"}, done_cyc[0], wr_cyc[wr_cyc.size()-1] + 1);
            chk({tag, "_rdylat"}, rdy_cyc[0], done_cyc[0] + 1);
        end else begin
            chk({tag, "_events"}, 0, 1);
        end
    endtask

    initial begin
        int  k;
        bit  zhit;
        reset_n = 1'b0; zeroize = 1'b0; wr_enable = 1'b0; zero_fill = 1'b0;
        mem_base_addr = '0; bus.data_valid_i = 1'b0; bus.data_i = '0;
        #12;
        chk("rst_rw", bus.mem_wr_req.rd_wr_en, RW_IDLE);
        chk("rst_addr", bus.mem_wr_req.addr, 0);
        chk("rst_data", bus.mem_wr_data, 0);
        chk("rst_dready", bus.data_ready_o, 0);
        chk("rst_done", wr_done, 0);
        chk("rst_wrready", wr_ready, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // back-to-back stream
        run_stream("bb", 15'h0040, 1'b0, 1'b0, 1'b0, 0);
        check_writes("bb", 15'h0040, 0, 0);
        if (wr_cyc.size() == 64) chk("bb_consec", wr_cyc[63] - wr_cyc[0], 63);

        // gapped stream: every other cycle idle
        run_stream("gap", 15'h0200, 1'b1, 1'b0, 1'b0, 100);
        check_writes("gap", 15'h0200, 0, 100);
        for (int j = 0; j < 63 && j + 1 < wr_cyc.size(); j++)
            chk($sformatf("gap_spacing%0d", j), wr_cyc[j+1] - wr_cyc[j], 2);

        // lane MSB masking
        run_stream("ones", 15'h0300, 1'b0, 1'b1, 1'b0, 0);
        check_writes("ones", 15'h0300, 1, 0);

        // zero fill with valid held high (must be ignored)
        clr_logs();
        bus.data_valid_i = 1'b1; bus.data_i = {96{1'b1}};
        start(15'h0100, 1'b1);
        wait_rdy(100);
        bus.data_valid_i = 1'b0;
        check_writes("fill", 15'h0100, 2, 0);
        chk("fill_dready_hi", rdy_hi, 0);
        if (wr_cyc.size() == 64 && done_cyc.size() == 1 && rdy_cyc.size() == 1) begin
            chk("fill_first", wr_cyc[0], en_cyc + 1);
            chk("fill_last", wr_cyc[63], en_cyc + 64);
            chk("fill_done", done_cyc[0], en_cyc + 65);
            chk("fill_rdy", rdy_cyc[0], en_cyc + 66);
        end else begin
            chk("fill_events", 0, 1);
        end

        // address wrap
        clr_logs();
        start(15'h7FFE, 1'b1);
        wait_rdy(100);
        check_writes("wrap", 15'h7FFE, 2, 0);
        if (wr_addr.size() >= 64) begin
            chk("wrap_a0", wr_addr[0], 15'h7FFE);
            chk("wrap_a1", wr_addr[1], 15'h7FFF);
            chk("wrap_a2", wr_addr[2], 15'h0000);
            chk("wrap_a63", wr_addr[63], 15'h003D);
        end

        // zeroize once the 10th write is on the bus
        clr_logs();
        start(15'h0040, 1'b0);
        k = 0; zhit = 1'b0;
        for (int t = 0; t < 200 && !zhit; t++) begin
            bus.data_valid_i = 1'b1; bus.data_i = mk(k);
            if (bus.data_ready_o) k++;
            @(negedge clk); #1;
            if (wr_addr.size() == 10) zeroize = 1'b1;
            @(posedge clk); #1;
            if (zeroize) begin zeroize = 1'b0; zhit = 1'b1; end
        end
        chk("zz_hit", zhit, 1'b1);
        chk("zz_rw", bus.mem_wr_req.rd_wr_en, RW_IDLE);
        chk("zz_addr", bus.mem_wr_req.addr, 0);
        chk("zz_data", bus.mem_wr_data, 0);
        chk("zz_dready", bus.data_ready_o, 0);
        repeat (20) begin @(posedge clk); #1; end
        bus.data_valid_i = 1'b0;
        chk("zz_nwr", wr_addr.size(), 10);
        chk("zz_ndone", done_cyc.size(), 0);
        chk("zz_nrdy", rdy_cyc.size(), 0);

        // restart after zeroize, with a stray wr_enable mid-stream
        run_stream("poke", 15'h0500, 1'b0, 1'b0, 1'b1, 7);
        check_writes("poke", 15'h0500, 0, 7);

        // asynchronous reset mid-fill
        clr_logs();
        start(15'h0040, 1'b1);
        repeat (5) begin @(posedge clk); #1; end
        chk("mr_pre_rw", bus.mem_wr_req.rd_wr_en, RW_WRITE);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_rw", bus.mem_wr_req.rd_wr_en, RW_IDLE);
        chk("mr_addr", bus.mem_wr_req.addr, 0);
        #2 reset_n = 1'b1;
        repeat (80) begin @(posedge clk); #1; end
        chk("mr_ndone", done_cyc.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
